// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM encoding and width helpers for fifo_wr_arbiter.
package fifo_arb_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int id_w(input int n);
        return clog2(n) < 1 ? 1 : clog2(n);
    endfunction
endpackage

// File: rtl/fifo_wr_arbiter_pick.sv
// rr_priority_pick: first set request at or above rr_ptr, wrapping around.
module rr_priority_pick import fifo_arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);
    logic [2*NUM_REQ-1:0] dbl;
    // Lower copy masked below rr_ptr, so the lowest set bit is the wrapped winner.
    always_comb begin
        dbl = {req, req & ({NUM_REQ{1'b1}} << rr_ptr)};
        found = 1'b0;
        idx = '0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (dbl[i]) begin
                found = 1'b1;
                idx = ID_W'(i % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst-locking arbiter onto one sync_fifo write port.
// Define FIFO_ARB_TAG_EN to prepend the owner ID to fifo_data_in.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN = 4,
    localparam int ID_W = id_w(NUM_REQ),
`ifdef FIFO_ARB_TAG_EN
    localparam int FIFO_W = DATA_WIDTH + ID_W
`else
    localparam int FIFO_W = DATA_WIDTH
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [FIFO_W-1:0]             fifo_data_in,
    output logic                          busy,
    output logic [ID_W-1:0]               owner
);
    localparam int CNT_W = id_w(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [ID_W-1:0] TOP = ID_W'(NUM_REQ - 1);
    state_t state;
    logic [ID_W-1:0] rr_ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic found;
    logic [ID_W-1:0] idx;
    logic live;
    logic own_valid;
    logic [DATA_WIDTH-1:0] data;
    rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req(req_valid),
        .rr_ptr(rr_ptr),
        .found(found),
        .idx(idx)
    );
    // Gating with rst keeps a word offered in the reset cycle out of the FIFO.
    always_comb begin
        live = state == ST_BURST && !rst && !fifo_full;
        own_valid = req_valid[owner];
        data = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
        fifo_wr_en = live && own_valid;
        req_ready = live ? NUM_REQ'(1) << owner : '0;
    end
`ifdef FIFO_ARB_TAG_EN
    assign fifo_data_in = {owner, data};
`else
    assign fifo_data_in = data;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            rr_ptr <= '0;
            owner <= '0;
            beat_cnt <= '0;
            busy <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (found) begin
                state <= ST_BURST;
                busy <= 1'b1;
                owner <= idx;
                beat_cnt <= '0;
            end
        end else if (!fifo_full) begin
            if (!own_valid || beat_cnt == LAST) begin
                state <= ST_IDLE;
                busy <= 1'b0;
                rr_ptr <= owner == TOP ? '0 : owner + 1'b1;
            end
            if (own_valid) beat_cnt <= beat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: random producers/full/reset against a grant-level model with a per-cycle scoreboard.
module tb_fifo_wr_arbiter;
    localparam int N = 4;
    localparam int DW = 32;
    localparam int BL = 4;
`ifdef FIFO_ARB_TAG_EN
    localparam int FW = DW + 2;
`else
    localparam int FW = DW;
`endif
    typedef struct {
        logic          wr;
        logic [FW-1:0] d;
        logic [N-1:0]  rdy;
        logic          busy;
        logic [1:0]    own;
        int            cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0] req_ready;
    logic fifo_full = 1'b0;
    logic fifo_wr_en;
    logic [FW-1:0] fifo_data_in;
    logic busy;
    logic [1:0] owner;
    exp_t q[$];
    int n_vec = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_data_in(fifo_data_in),
        .busy(busy),
        .owner(owner)
    );
    task automatic chk(input string nm, input int cyc, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask
    // Driver + reference model: holder is the granted producer (-1 when idle), ptr the scan start.
    initial begin
        int holder = -1;
        int ptr = 0;
        int last = 0;
        int taken = 0;
        logic [N-1:0] mask;
        exp_t e;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            mask = cyc < 120 ? 4'b0100 : cyc < 400 ? 4'b1011 : 4'b1111;
            rst = cyc < 2 || $urandom_range(0, 79) == 0;
            fifo_full = cyc >= 120 && $urandom_range(0, 4) == 0;
            for (int i = 0; i < N; i++) begin
                req_valid[i] = mask[i] && (req_valid[i] ? $urandom_range(0, 9) != 0 : $urandom_range(0, 2) == 0);
                req_data[i*DW +: DW] = $urandom;
            end
            #2;
            e.wr = 1'b0;
            e.d = '0;
            e.rdy = '0;
            e.busy = holder >= 0;
            e.own = 2'(last);
            e.cyc = cyc;
            if (rst) begin
                holder = -1;
                ptr = 0;
                last = 0;
            end else if (holder < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (req_valid[(ptr + k) % N]) begin
                        holder = (ptr + k) % N;
                        break;
                    end
                end
                if (holder >= 0) begin
                    last = holder;
                    taken = 0;
                end
            end else if (!fifo_full) begin
                e.rdy = N'(1 << holder);
                e.wr = req_valid[holder];
`ifdef FIFO_ARB_TAG_EN
                e.d = {2'(holder), req_data[holder*DW +: DW]};
`else
                e.d = req_data[holder*DW +: DW];
`endif
                if (req_valid[holder]) taken++;
                if (!req_valid[holder] || taken == BL) begin
                    ptr = (holder + 1) % N;
                    holder = -1;
                end
            end
            q.push_back(e);
        end
        @(negedge clk);
        #6;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
    // Monitor: pops one expectation per cycle and compares the DUT's visible outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (q.size() == 0) continue;
            e = q.pop_front();
            chk("wr_en", e.cyc, 64'(fifo_wr_en), 64'(e.wr));
            chk("req_ready", e.cyc, 64'(req_ready), 64'(e.rdy));
            chk("busy", e.cyc, 64'(busy), 64'(e.busy));
            chk("owner", e.cyc, 64'(owner), 64'(e.own));
            if (e.wr) chk("data", e.cyc, 64'(fifo_data_in), 64'(e.d));
        end
    end
endmodule
